bus_pair_rx_fifo: RTL

- Receiving end of a two-bus link: accepts one beat per handshake of a descending-indexed bus (i0, [MSB:LSB]) and an ascending-indexed bus (i1, [LSB:MSB]).
- Buffers beats in a small FIFO and presents them as one packed little-endian word to the consumer.
- Checks sender protocol, i.e. that data stays stable while stalled, and flags violations.
- Sits downstream of the block that drives o0/o1 pairs.

---
 rtl/bus_pair_rx_fifo.sv | 59 +++++
 1 files changed

// File: rtl/bus_pair_rx_fifo.sv
// bus_pair_rx_fifo: two-bus beat receiver with FIFO buffering and sender stall-stability checking
module bus_pair_rx_fifo #(
  parameter int MSB = 2,
  parameter int LSB = -2,
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [MSB:LSB]                       i0,
  input  logic [LSB:MSB]                       i1,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*(MSB-LSB+1)-1:0]             out_data,
  output logic [$clog2(DEPTH):0]               count,
  output logic [7:0]                           beat_cnt,
  output logic                                 proto_err
);
  localparam int W = MSB - LSB + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [2*W-1:0] mem [DEPTH];
  logic [2*W-1:0] din, held;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] cnt_nxt;
  logic push, pop, stall_q;
  assign din = {i0, i1};
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_valid = count != '0;
  assign rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign cnt_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // out_data tracks the next head; a beat entering an empty queue bypasses mem
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_ready <= 1'b0;
      out_data <= '0;
      beat_cnt <= '0;
      proto_err <= 1'b0;
      stall_q <= 1'b0;
      held <= '0;
    end else begin
      count <= cnt_nxt;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_nxt;
      in_ready <= cnt_nxt != FULL;
      out_data <= cnt_nxt == '0 ? out_data : (push && rd_nxt == wr_ptr) ? din : mem[rd_nxt];
      beat_cnt <= beat_cnt + 8'(push);
      proto_err <= proto_err | (stall_q && (!in_valid || din != held));
      stall_q <= in_valid && !in_ready;
      held <= din;
    end
endmodule
